// File: rtl/vga_mem_arbiter.sv
// Arbitrates one single-port framebuffer RAM between display refill and draw/host; gnt is same-cycle, mem_* one cycle later, read data 1+RD_LAT after gnt.
// Requesters hold req until gnt; display wins in active video, draw wins in blanking, and a starvation counter forces a draw slot.
module vga_mem_arbiter #(
  parameter int AW       = 17,
  parameter int DW       = 8,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          blank,
  input  logic          disp_urgent,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_gnt,
  output logic          disp_rvalid,
  output logic [DW-1:0] disp_rdata,
  input  logic          draw_req,
  input  logic          draw_we,
  input  logic [AW-1:0] draw_addr,
  input  logic [DW-1:0] draw_wdata,
  output logic          draw_gnt,
  output logic          draw_rvalid,
  output logic [DW-1:0] draw_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {ST_ACTIVE, ST_BLANK, ST_STARVE} state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_DRAW} tag_t;

  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

  state_t          state_q, state_d;
  logic [7:0]      wait_cnt_q, wait_cnt_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  tag_t            mem_tag_q, mem_tag_d;
  tag_t            tag_q [RD_LAT];
  tag_t            tag_d [RD_LAT];

  always_comb begin
    disp_gnt = 1'b0;
    draw_gnt = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_ACTIVE: begin
          if (disp_req)      disp_gnt = 1'b1;
          else if (draw_req) draw_gnt = 1'b1;
        end
        ST_BLANK: begin
          if (draw_req)      draw_gnt = 1'b1;
          else if (disp_req) disp_gnt = 1'b1;
        end
        ST_STARVE: draw_gnt = draw_req;
        default: ;
      endcase
    end
  end

  // Transition to STARVE looks at the count including this cycle's denial,
  // so a draw is refused at most MAX_WAIT times before its forced slot.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!draw_req || draw_gnt)
      wait_cnt_d = '0;
    else if (wait_cnt_q != WAIT_MAX)
      wait_cnt_d = wait_cnt_q + 8'd1;

    state_d = state_q;
    case (state_q)
      ST_ACTIVE: begin
        if (blank)
          state_d = ST_BLANK;
        else if (draw_req && !disp_urgent && wait_cnt_d == WAIT_MAX)
          state_d = ST_STARVE;
      end
      ST_BLANK:  if (!blank) state_d = ST_ACTIVE;
      ST_STARVE: state_d = blank ? ST_BLANK : ST_ACTIVE;
      default:   state_d = ST_ACTIVE;
    endcase
  end

  always_comb begin
    mem_en_d    = disp_gnt | draw_gnt;
    mem_we_d    = draw_gnt & draw_we;
    mem_addr_d  = draw_gnt ? draw_addr : (disp_gnt ? disp_addr : '0);
    mem_wdata_d = draw_gnt ? draw_wdata : '0;
    if (disp_gnt)
      mem_tag_d = TAG_DISP;
    else if (draw_gnt && !draw_we)
      mem_tag_d = TAG_DRAW;
    else
      mem_tag_d = TAG_NONE;

    tag_d[0] = mem_tag_q;
    for (int i = 1; i < RD_LAT; i++)
      tag_d[i] = tag_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACTIVE;
      wait_cnt_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_tag_q   <= TAG_NONE;
      for (int i = 0; i < RD_LAT; i++)
        tag_q[i] <= TAG_NONE;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_tag_q   <= mem_tag_d;
      for (int i = 0; i < RD_LAT; i++)
        tag_q[i] <= tag_d[i];
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  assign disp_rvalid = !rst && (tag_q[RD_LAT-1] == TAG_DISP);
  assign draw_rvalid = !rst && (tag_q[RD_LAT-1] == TAG_DRAW);
  assign disp_rdata  = disp_rvalid ? mem_rdata : '0;
  assign draw_rdata  = draw_rvalid ? mem_rdata : '0;

endmodule
